// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the shared-multiplier sequencer.
//   - RV32M multiply op encodings as carried on req_op
//   - sequencer state constants
//   - signedness codes (bit1 = multiplicand/rs1 signed, bit0 = multiplier/rs2 signed)
//   - op_sgn(): op -> signedness code
package mul_pkg;

    localparam logic [1:0] MUL_OP    = 2'b00;
    localparam logic [1:0] MULH_OP   = 2'b01;
    localparam logic [1:0] MULHSU_OP = 2'b10;
    localparam logic [1:0] MULHU_OP  = 2'b11;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] SGN_UU = 2'b00;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_SS = 2'b11;

    // MUL only returns the low half, which does not depend on signedness,
    // so it runs as unsigned.
    function automatic logic [1:0] op_sgn(input logic [1:0] op);
        logic [1:0] s;
        case (op)
            MULH_OP:   s = SGN_SS;
            MULHSU_OP: s = SGN_SU;
            default:   s = SGN_UU;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: iterative sign-magnitude shift-and-add multiplier.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle pulse; samples operand magnitudes
//   multiplicand    N-bit rs1 operand
//   multiplier      N-bit rs2 operand
//   is_signed[1:0]  bit1 = multiplicand signed, bit0 = multiplier signed
//   finished        high once the multiplier magnitude is exhausted
//   product         2N-bit result, sign applied combinationally
// One multiplier bit is consumed per cycle and the run ends as soon as the
// remaining magnitude is zero, so a run takes (highest set bit + 1) cycles
// after start. The final sign is derived from the live operand inputs, which
// therefore must be held stable by the caller until the product is used.
module shift_add_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    input  logic [1:0]     is_signed,
    output logic           finished,
    output logic [2*N-1:0] product
);

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    logic           run_q,      run_d;
    logic [N-1:0]   mplier_q,   mplier_d;
    logic [2*N-1:0] mcand_sh_q, mcand_sh_d;
    logic [2*N-1:0] acc_q,      acc_d;

    logic           mcand_neg, mplier_neg, prod_neg;
    logic [N-1:0]   mcand_mag, mplier_mag;

    assign mcand_neg  = is_signed[1] & multiplicand[N-1];
    assign mplier_neg = is_signed[0] & multiplier[N-1];
    assign prod_neg   = mcand_neg ^ mplier_neg;

    // Magnitude of the most negative value still fits as an unsigned N-bit number.
    assign mcand_mag  = mcand_neg  ? (~multiplicand + ONE_N) : multiplicand;
    assign mplier_mag = mplier_neg ? (~multiplier   + ONE_N) : multiplier;

    always_comb begin
        run_d      = run_q;
        mplier_d   = mplier_q;
        mcand_sh_d = mcand_sh_q;
        acc_d      = acc_q;
        if (start) begin
            run_d      = 1'b1;
            mplier_d   = mplier_mag;
            mcand_sh_d = {{N{1'b0}}, mcand_mag};
            acc_d      = '0;
        end else if (run_q && (mplier_q != '0)) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_sh_q;
            end
            mcand_sh_d = mcand_sh_q << 1;
            mplier_d   = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            mplier_q   <= '0;
            mcand_sh_q <= '0;
            acc_q      <= '0;
        end else begin
            run_q      <= run_d;
            mplier_q   <= mplier_d;
            mcand_sh_q <= mcand_sh_d;
            acc_q      <= acc_d;
        end
    end

    // Cleared by the start edge because run/mplier are reloaded there.
    assign finished = run_q && (mplier_q == '0);
    assign product  = prod_neg ? (~acc_q + {{(2*N-1){1'b0}}, 1'b1}) : acc_q;

endmodule

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shares one shift_add_multiplier between two requesters.
// Ports:
//   CLK, nRST       clock, asynchronous active-low reset
//   req_valid[1:0]  per-requester request valid
//   req_ready[1:0]  per-requester accept (at most one bit high, IDLE only)
//   req_op[3:0]     op per requester, [2i+1:2i]: MUL/MULH/MULHSU/MULHU
//   req_a/req_b     rs1/rs2 per requester, [N*i+N-1:N*i]
//   resp_valid[1:0] one-hot response valid
//   resp_ready[1:0] per-requester response accept
//   resp_data       selected 32-bit half for the flagged requester
//   busy            high whenever the sequencer is not IDLE
// A one-entry cache of the last computed product lets a high/low pair on the
// same operands complete without running the core a second time.
module mul_share_ctrl
    import mul_pkg::*;
#(
    parameter int N = 32
) (
    input  logic           CLK,
    input  logic           nRST,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [3:0]     req_op,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    output logic [1:0]     resp_valid,
    input  logic [1:0]     resp_ready,
    output logic [N-1:0]   resp_data,
    output logic           busy
);

    logic [1:0]     state_q,       state_d;
    logic           id_q,          id_d;
    logic [1:0]     op_q,          op_d;
    logic [N-1:0]   a_q,           a_d;
    logic [N-1:0]   b_q,           b_d;
    logic           rr_ptr_q,      rr_ptr_d;
    logic           cache_valid_q, cache_valid_d;
    logic [N-1:0]   cache_a_q,     cache_a_d;
    logic [N-1:0]   cache_b_q,     cache_b_d;
    logic [1:0]     cache_sgn_q,   cache_sgn_d;
    logic [2*N-1:0] cache_prod_q,  cache_prod_d;
    logic [N-1:0]   resp_data_q,   resp_data_d;

    logic [1:0]     op_arr [2];
    logic [N-1:0]   a_arr  [2];
    logic [N-1:0]   b_arr  [2];

    logic [1:0]     grant;
    logic           gnt_id;
    logic           accept;
    logic [1:0]     sel_op;
    logic [N-1:0]   sel_a, sel_b;
    logic           hit;

    logic           core_start;
    logic [1:0]     core_sgn;
    logic           core_finished;
    logic [2*N-1:0] core_product;

    function automatic logic [N-1:0] pick_half(input logic [1:0] op, input logic [2*N-1:0] prod);
        return (op == MUL_OP) ? prod[N-1:0] : prod[2*N-1:N];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign op_arr[gi]     = req_op[2*gi +: 2];
            assign a_arr[gi]      = req_a[N*gi +: N];
            assign b_arr[gi]      = req_b[N*gi +: N];
            assign resp_valid[gi] = (state_q == RESP) && (id_q == 1'(gi));
        end
    endgenerate

    // Grant is qualified by nRST so req_ready reads 0 while reset is held.
    always_comb begin
        grant = 2'b00;
        if ((state_q == IDLE) && nRST) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign gnt_id    = grant[1];
    assign accept    = |grant;
    assign sel_op    = op_arr[gnt_id];
    assign sel_a     = a_arr[gnt_id];
    assign sel_b     = b_arr[gnt_id];

    // The low half is signedness-independent, so MUL may reuse any cached sign mode.
    assign hit = cache_valid_q && (sel_a == cache_a_q) && (sel_b == cache_b_q) &&
                 ((sel_op == MUL_OP) || (op_sgn(sel_op) == cache_sgn_q));

    always_comb begin
        state_d       = state_q;
        id_d          = id_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        rr_ptr_d      = rr_ptr_q;
        cache_valid_d = cache_valid_q;
        cache_a_d     = cache_a_q;
        cache_b_d     = cache_b_q;
        cache_sgn_d   = cache_sgn_q;
        cache_prod_d  = cache_prod_q;
        resp_data_d   = resp_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d     = gnt_id;
                    op_d     = sel_op;
                    a_d      = sel_a;
                    b_d      = sel_b;
                    rr_ptr_d = ~gnt_id;
                    if (hit) begin
                        resp_data_d = pick_half(sel_op, cache_prod_q);
                        state_d     = RESP;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: state_d = BUSY;
            BUSY: begin
                if (core_finished) begin
                    cache_valid_d = 1'b1;
                    cache_a_d     = a_q;
                    cache_b_d     = b_q;
                    cache_sgn_d   = core_sgn;
                    cache_prod_d  = core_product;
                    resp_data_d   = pick_half(op_q, core_product);
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (resp_ready[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            id_q          <= 1'b0;
            op_q          <= MUL_OP;
            a_q           <= '0;
            b_q           <= '0;
            rr_ptr_q      <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_a_q     <= '0;
            cache_b_q     <= '0;
            cache_sgn_q   <= SGN_UU;
            cache_prod_q  <= '0;
            resp_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            rr_ptr_q      <= rr_ptr_d;
            cache_valid_q <= cache_valid_d;
            cache_a_q     <= cache_a_d;
            cache_b_q     <= cache_b_d;
            cache_sgn_q   <= cache_sgn_d;
            cache_prod_q  <= cache_prod_d;
            resp_data_q   <= resp_data_d;
        end
    end

    // Core operands come only from the latched registers so they stay fixed
    // through START and BUSY regardless of what the requesters do.
    assign core_start = (state_q == START);
    assign core_sgn   = op_sgn(op_q);

    shift_add_multiplier #(
        .N(N)
    ) u_core (
        .clk          (CLK),
        .rst_n        (nRST),
        .start        (core_start),
        .multiplicand (a_q),
        .multiplier   (b_q),
        .is_signed    (core_sgn),
        .finished     (core_finished),
        .product      (core_product)
    );

    assign resp_data = resp_data_q;
    assign busy      = (state_q != IDLE);

endmodule
